flag_branch_unit: RTL and testbench

- Consumes the ALU status outputs (ov, zr, ne) and holds the architectural flag register Z/V/N.
- Resolves conditional branches against those flags and issues a registered PC redirect, followed by a fixed-length pipeline flush.
- Sits between EX (flag producer) and fetch (redirect consumer) in the 16-bit CPU.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/branch_cond_eval.sv | 28 ++
 rtl/flag_branch_unit.sv | 144 ++++++++++++++
 tb/tb_flag_branch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, branch-unit state encoding and flag indices.
package cpu_pkg;

  // Branch condition codes (br_cond encoding)
  localparam logic [2:0] COND_NEQ    = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_GT     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GTE    = 3'd4;
  localparam logic [2:0] COND_LTE    = 3'd5;
  localparam logic [2:0] COND_OV     = 3'd6;
  localparam logic [2:0] COND_UNCOND = 3'd7;

  // Branch unit FSM states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  // Bit positions inside the architectural flag register
  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_V    = 1;
  localparam int unsigned FLAG_N    = 2;
  localparam int unsigned NUM_FLAGS = 3;

  // PC-relative target: 16-bit modular add of the sign-extended 9-bit word offset.
  function automatic logic [15:0] branch_target(input logic [15:0] pc_plus1,
                                                input logic [8:0]  offset);
    return pc_plus1 + {{7{offset[8]}}, offset};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition evaluator: (cond, Z, V, N) -> taken.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic       ez,
  input  logic       ev,
  input  logic       en,
  output logic       taken
);

  // Decode the condition code against the effective flags
  always_comb begin
    taken = 1'b0;
    unique case (br_cond)
      COND_NEQ:    taken = ~ez;
      COND_EQ:     taken = ez;
      COND_GT:     taken = ~ez & ~en;
      COND_LT:     taken = en;
      COND_GTE:    taken = ez | ~en;
      COND_LTE:    taken = en | ez;
      COND_OV:     taken = ev;
      COND_UNCOND: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register plus conditional-branch resolver: holds Z/V/N, resolves branches,
// issues a registered one-cycle PC redirect and a fixed-length flush.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          FORWARD      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flag_we_z,
  input  logic        flag_we_vn,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_ne,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_pc_plus1,
  input  logic [8:0]  br_offset,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("flag_branch_unit: FLUSH_CYCLES must be in 1..7");
  end

  localparam logic [2:0] CntLoad = 3'(FLUSH_CYCLES - 1);

  logic [NUM_FLAGS-1:0] flags_q;
  logic                 ez, ev, en;
  logic                 cond_true;
  logic                 accept;
  logic [15:0]          target;

  br_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;

  // Architectural flag register; writes are frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (!stall) begin
      if (flag_we_z) begin
        flags_q[FLAG_Z] <= alu_zr;
      end
      if (flag_we_vn) begin
        flags_q[FLAG_V] <= alu_ov;
        flags_q[FLAG_N] <= alu_ne;
      end
    end
  end

  // Effective flags: optionally bypass the ALU result written this same cycle
  always_comb begin
    ez = (FORWARD && flag_we_z)  ? alu_zr : flags_q[FLAG_Z];
    ev = (FORWARD && flag_we_vn) ? alu_ov : flags_q[FLAG_V];
    en = (FORWARD && flag_we_vn) ? alu_ne : flags_q[FLAG_N];
  end

  branch_cond_eval u_cond_eval (
    .br_cond (br_cond),
    .ez      (ez),
    .ev      (ev),
    .en      (en),
    .taken   (cond_true)
  );

  assign target = branch_target(br_pc_plus1, br_offset);
  // Branches arriving during FLUSH are younger squashed instructions
  assign accept = (state_q == ST_IDLE) && br_valid && cond_true;

  // State, counter and registered outputs; everything holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 16'h0000;
      flush_q          <= 1'b0;
    end else if (!stall) begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FLUSH;
      ST_FLUSH: if (cnt_q == 3'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the flush counter
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    cnt_d            = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          flush_d          = 1'b1;
          cnt_d            = CntLoad;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        flush_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign flag_z         = flags_q[FLAG_Z];
  assign flag_v         = flags_q[FLAG_V];
  assign flag_n         = flags_q[FLAG_N];

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed vector table, async-reset corner, then random
// stimulus against a cycle-level reference model. Two DUTs: FORWARD=1 and FORWARD=0.
module tb_flag_branch_unit;

  localparam int FLUSH = 2;

  logic        clk, rst_n, stall;
  logic        flag_we_z, flag_we_vn, alu_ov, alu_zr, alu_ne;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_pc_plus1;
  logic [8:0]  br_offset;

  // index 1: FORWARD=1 instance, index 0: FORWARD=0 instance
  logic        rv [2];
  logic [15:0] rpc [2];
  logic        fl [2];
  logic        fz [2];
  logic        fv [2];
  logic        fn [2];

  int checks = 0;
  int errors = 0;

  flag_branch_unit #(.FLUSH_CYCLES(FLUSH), .FORWARD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we_z(flag_we_z),
    .flag_we_vn(flag_we_vn), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_ne(alu_ne),
    .br_valid(br_valid), .br_cond(br_cond), .br_pc_plus1(br_pc_plus1),
    .br_offset(br_offset), .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
    .flush(fl[1]), .flag_z(fz[1]), .flag_v(fv[1]), .flag_n(fn[1])
  );

  flag_branch_unit #(.FLUSH_CYCLES(FLUSH), .FORWARD(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we_z(flag_we_z),
    .flag_we_vn(flag_we_vn), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_ne(alu_ne),
    .br_valid(br_valid), .br_cond(br_cond), .br_pc_plus1(br_pc_plus1),
    .br_offset(br_offset), .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
    .flush(fl[0]), .flag_z(fz[0]), .flag_v(fv[0]), .flag_n(fn[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_z [2], m_v [2], m_n [2], m_rv [2];
  logic [15:0] m_pc [2];
  int          m_left [2];   // flush cycles still to be shown, including the current one

  function automatic bit cond_ok(input logic [2:0] c, input bit z, input bit v, input bit n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_z[k] = 0; m_v[k] = 0; m_n[k] = 0; m_rv[k] = 0; m_pc[k] = 16'h0; m_left[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit ez, ev, en;
    int signed off;
    for (int k = 0; k < 2; k++) begin
      if (!stall) begin
        ez = (k == 1 && flag_we_z)  ? alu_zr : m_z[k];
        ev = (k == 1 && flag_we_vn) ? alu_ov : m_v[k];
        en = (k == 1 && flag_we_vn) ? alu_ne : m_n[k];
        if (m_left[k] == 0) begin
          if (br_valid && cond_ok(br_cond, ez, ev, en)) begin
            off = br_offset[8] ? int'(br_offset) - 512 : int'(br_offset);
            m_rv[k]   = 1;
            m_pc[k]   = 16'((int'(br_pc_plus1) + off + 65536) % 65536);
            m_left[k] = FLUSH;
          end
        end else begin
          m_rv[k] = 0;
          m_left[k]--;
        end
        if (flag_we_z) m_z[k] = alu_zr;
        if (flag_we_vn) begin
          m_v[k] = alu_ov;
          m_n[k] = alu_ne;
        end
      end
    end
  endtask

  task automatic model_check(input int cyc);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rnd%0d_fwd%0d_rv", cyc, k), 16'(rv[k]), 16'(m_rv[k]));
      chk($sformatf("rnd%0d_fwd%0d_pc", cyc, k), rpc[k], m_pc[k]);
      chk($sformatf("rnd%0d_fwd%0d_flush", cyc, k), 16'(fl[k]), 16'(m_left[k] > 0));
      chk($sformatf("rnd%0d_fwd%0d_z", cyc, k), 16'(fz[k]), 16'(m_z[k]));
      chk($sformatf("rnd%0d_fwd%0d_v", cyc, k), 16'(fv[k]), 16'(m_v[k]));
      chk($sformatf("rnd%0d_fwd%0d_n", cyc, k), 16'(fn[k]), 16'(m_n[k]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall, we_z, we_vn, ov, zr, ne, bv;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [8:0]  off;
    logic        rv;      // expectations for FORWARD=1 instance
    logic [15:0] rpc;
    logic        fl, z, v, n;
    logic        rv_nf;   // expectations for FORWARD=0 instance
    logic        fl_nf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, wz, wvn, ov, zr, ne, bv, input logic [2:0] c,
                              input logic [15:0] pc, input logic [8:0] off,
                              input logic erv, input logic [15:0] epc,
                              input logic efl, ez, ev, en, erv_nf, efl_nf);
    vec_t t;
    t.stall = s; t.we_z = wz; t.we_vn = wvn; t.ov = ov; t.zr = zr; t.ne = ne; t.bv = bv;
    t.cond = c; t.pc = pc; t.off = off;
    t.rv = erv; t.rpc = epc; t.fl = efl; t.z = ez; t.v = ev; t.n = en;
    t.rv_nf = erv_nf; t.fl_nf = efl_nf;
    return t;
  endfunction

  task automatic drive_idle();
    stall = 0; flag_we_z = 0; flag_we_vn = 0; alu_ov = 0; alu_zr = 0; alu_ne = 0;
    br_valid = 0; br_cond = 3'd0; br_pc_plus1 = 16'h0; br_offset = 9'h0;
  endtask

  initial begin
    drive_idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_fwd%0d_rv", k), 16'(rv[k]), 16'h0);
      chk($sformatf("reset_fwd%0d_pc", k), rpc[k], 16'h0);
      chk($sformatf("reset_fwd%0d_flush", k), 16'(fl[k]), 16'h0);
      chk($sformatf("reset_fwd%0d_flags", k), {13'h0, fn[k], fv[k], fz[k]}, 16'h0);
    end
    rst_n = 1;

    //            st wz wv ov zr ne bv cond  pc        off     rv rpc       fl z  v  n  rvn fln
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd1, 16'h0010, 9'h1FE, 1, 16'h000E, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h000E, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h000E, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h000E, 0, 0, 0, 0, 0, 0));
    // forwarded Z makes EQ taken only in the FORWARD=1 instance
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 3'd1, 16'h0100, 9'h005, 1, 16'h0105, 1, 1, 0, 0, 0, 0));
    // UNCOND inside the flush window is squashed (FORWARD=0 instance is idle and takes it)
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd7, 16'h0200, 9'h000, 0, 16'h0105, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd7, 16'h0200, 9'h000, 0, 16'h0105, 0, 1, 0, 0, 0, 1));
    // NEQ with Z=1 is not taken
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd0, 16'h0300, 9'h001, 0, 16'h0105, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h0105, 0, 0, 0, 0, 0, 0));
    // taken GT, then three stalled cycles with writes and a branch that must all be ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd2, 16'h0020, 9'h010, 1, 16'h0030, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 3'd7, 16'h0400, 9'h000, 1, 16'h0030, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 3'd7, 16'h0400, 9'h000, 1, 16'h0030, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 3'd7, 16'h0400, 9'h000, 1, 16'h0030, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h0030, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h0030, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h0030, 0, 0, 1, 1, 0, 0));
    // target wrap-around
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd7, 16'hFFFF, 9'h002, 1, 16'h0001, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 0, 16'h0001, 1, 0, 1, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; flag_we_z = vecs[i].we_z; flag_we_vn = vecs[i].we_vn;
      alu_ov = vecs[i].ov; alu_zr = vecs[i].zr; alu_ne = vecs[i].ne;
      br_valid = vecs[i].bv; br_cond = vecs[i].cond;
      br_pc_plus1 = vecs[i].pc; br_offset = vecs[i].off;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_rv", i), 16'(rv[1]), 16'(vecs[i].rv));
      chk($sformatf("vec%0d_pc", i), rpc[1], vecs[i].rpc);
      chk($sformatf("vec%0d_flush", i), 16'(fl[1]), 16'(vecs[i].fl));
      chk($sformatf("vec%0d_flags", i), {13'h0, fn[1], fv[1], fz[1]},
          {13'h0, vecs[i].n, vecs[i].v, vecs[i].z});
      chk($sformatf("vec%0d_nf_rv", i), 16'(rv[0]), 16'(vecs[i].rv_nf));
      chk($sformatf("vec%0d_nf_flush", i), 16'(fl[0]), 16'(vecs[i].fl_nf));
    end

    // Async reset mid-flush: outputs must clear without a clock edge
    drive_idle();
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_rst_fwd%0d_flush", k), 16'(fl[k]), 16'h0);
      chk($sformatf("async_rst_fwd%0d_rv", k), 16'(rv[k]), 16'h0);
      chk($sformatf("async_rst_fwd%0d_pc", k), rpc[k], 16'h0);
      chk($sformatf("async_rst_fwd%0d_flags", k), {13'h0, fn[k], fv[k], fz[k]}, 16'h0);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // Random phase against the reference model
    for (int c = 0; c < 800; c++) begin
      stall       = ($urandom_range(0, 5) == 0);
      flag_we_z   = 1'($urandom_range(0, 1));
      flag_we_vn  = 1'($urandom_range(0, 1));
      alu_ov      = 1'($urandom_range(0, 1));
      alu_zr      = 1'($urandom_range(0, 1));
      alu_ne      = 1'($urandom_range(0, 1));
      br_valid    = ($urandom_range(0, 2) != 0);
      br_cond     = 3'($urandom_range(0, 7));
      br_pc_plus1 = 16'($urandom);
      br_offset   = 9'($urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_check(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
